fifo_rd_stage: RTL and testbench
================================

FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

Interface
REQ-001 SHALL take parameter CNT_W, default 16, width of statistics counter word_cnt.
REQ-002 SHALL have port rd_clk  input  1  read-domain clock; all state on rising edge.
REQ-003 SHALL have port rd_rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have port en  input  1  drain enable; 0 blocks new FIFO pops.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_pop  output  1  FIFO pop request.
REQ-007 SHALL have port fifo_data  input  data_t (fifo_pkg)  FIFO read data, valid the cycle after an accepted pop.
REQ-008 SHALL have port m_data  output  data_t  downstream data.
REQ-009 SHALL have port m_valid  output  1  downstream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream ready.
REQ-011 SHALL have port word_cnt  output  CNT_W  count of downstream transfers.

Function
REQ-012 SHALL treat a pop as accepted when fifo_pop=1 and fifo_empty=0; fifo_pop SHALL never be 1 while fifo_empty=1.
REQ-013 SHALL hold a registered in-flight flag, set 1 cycle after an accepted pop, cleared otherwise.
REQ-014 SHALL capture fifo_data into a 3-entry circular buffer (2-bit wr/rd pointers, wrap 2->0) on every cycle the in-flight flag is 1.
REQ-015 SHALL drive fifo_pop = en & ~fifo_empty & (occ + inflight < 3); occ = buffer occupancy 0..3; no combinational path from m_ready to fifo_pop.
REQ-016 SHALL drive m_valid = (occ != 0) and m_data = buffer head, both from registers only.
REQ-017 SHALL retire the head on m_valid & m_ready; m_data/m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-018 SHALL handle simultaneous capture and retire in one cycle: occ unchanged, both pointers advance.
REQ-019 SHALL sustain 1 word/cycle when en=1, FIFO non-empty and m_ready held 1; first-word latency pop -> m_valid = 2 cycles.
REQ-020 SHALL preserve FIFO order with no loss or duplication.
REQ-021 SHALL, on en falling, issue no new pops but still capture a word already in flight and deliver all buffered words.
REQ-022 SHALL never overflow (occ + inflight <= 3 always); capture into a full buffer is a design error.

Reset
REQ-023 SHALL on rd_rst=0 immediately clear fifo_pop, m_valid, in-flight flag, pointers, occ, word_cnt to 0; m_data to 0.
REQ-024 SHALL discard buffered and in-flight words on reset mid-operation; FIFO read side is reset concurrently by the same rd_rst.
REQ-025 SHALL resume normal operation on the first rd_clk edge after rd_rst returns to 1.

Configuration
REQ-026 SHALL, with macro FIFO_RD_STATS_EN defined, increment word_cnt by 1 per m_valid & m_ready cycle, wrapping 2^CNT_W-1 -> 0.
REQ-027 SHALL, with FIFO_RD_STATS_EN undefined, keep word_cnt port present and tied to 0, with no counter logic.

Verification
REQ-028 SHALL cover: FIFO holds 0xA1,0xA2,0xA3, en=1, m_ready=1 -> m_data 0xA1,0xA2,0xA3 on 3 consecutive cycles, first 2 cycles after first pop.
REQ-029 SHALL cover: m_ready=0 with 5 words in FIFO -> exactly 3 pops, m_valid=1, m_data stable at word 0; m_ready=1 -> all 5 delivered in order.
REQ-030 SHALL cover: en dropped the cycle after a pop -> in-flight word delivered, fifo_pop stays 0 thereafter.
REQ-031 SHALL cover: fifo_empty=1 throughout -> fifo_pop=0, m_valid=0 for all cycles.
REQ-032 SHALL cover: rd_rst=0 asserted mid-stream with occ=2 -> m_valid, fifo_pop, word_cnt = 0 asynchronously, before next rd_clk edge.
REQ-033 SHALL cover: FIFO_RD_STATS_EN defined, CNT_W=4, 17 transfers -> word_cnt = 1; undefined -> word_cnt = 0.

Source files
------------

// File: rtl/fifo_rd_stage.sv
// ============================================================================
// Module      : fifo_rd_stage
// Description : Read-side drain stage that pops a FIFO into a 3-entry skid
//               buffer and presents the words on a valid/ready interface.
//               Optional transfer counter enabled by macro FIFO_RD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;
    typedef logic [7:0] data_t;
endpackage

module fifo_rd_stage
    import fifo_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  data_t            fifo_data,
    output data_t            m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [1:0] C_LAST_IDX = 2'd2;
    localparam logic [2:0] C_DEPTH    = 3'd3;

    data_t       buf_q [3];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic        inflight_q, inflight_d;
    logic        w_capture;
    logic        w_retire;
    logic [2:0]  w_level;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == C_LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf_q[rd_ptr_q];

    always_comb begin
        w_level    = {1'b0, occ_q} + {2'b00, inflight_q};
        // Gated by reset so the pop request drops immediately, not at the next edge.
        fifo_pop   = rd_rst & en & ~fifo_empty & (w_level < C_DEPTH);
        w_capture  = inflight_q;
        w_retire   = m_valid & m_ready;
        inflight_d = fifo_pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        if (w_capture) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (w_retire) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({w_capture, w_retire})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            buf_q[2]   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            if (w_capture) begin
                buf_q[wr_ptr_q] <= fifo_data;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] word_cnt_q;

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            word_cnt_q <= '0;
        end else if (w_retire) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stage.sv
// Testbench for fifo_rd_stage: FIFO model, outstanding-word reference model and
// an order scoreboard checked by an independent monitor.
`default_nettype none

module tb_fifo_rd_stage;
    import fifo_pkg::*;

    localparam int CNT_W = 4;

    logic             rd_clk = 1'b0;
    logic             rd_rst;
    logic             en;
    logic             fifo_empty;
    logic             fifo_pop;
    data_t            fifo_data;
    data_t            m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] word_cnt;

    fifo_rd_stage #(.CNT_W(CNT_W)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int    n_checks = 0;
    int    n_pass   = 0;

    data_t src_q[$];
    data_t exp_q[$];
    data_t mon_exp;
    int    outstanding = 0;
    int    inflight_m  = 0;
    int    delivered   = 0;
    bit    pop_acc_s, xfer_s;
    bit    prev_valid = 0, prev_ready = 0;
    data_t prev_data;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_cnt();
`ifdef FIFO_RD_STATS_EN
        return delivered % (1 << CNT_W);
`else
        return 0;
`endif
    endfunction

    // Scoreboard monitor: every downstream transfer must match the next popped word.
    always @(negedge rd_clk) begin
        if (rd_rst === 1'b1 && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("xfer_without_pending_word", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("m_data_order", int'(m_data), int'(mon_exp));
            end
        end
    end

    // Called at posedge+1; drives one cycle, checks at negedge, updates model.
    task automatic step(input bit en_v, input bit rdy_v, input int npush);
        en      = en_v;
        m_ready = rdy_v;
        for (int i = 0; i < npush; i++) src_q.push_back(data_t'($urandom_range(0, 255)));
        fifo_empty = (src_q.size() == 0);
        @(negedge rd_clk);
        chk("fifo_pop", int'(fifo_pop), int'(en && !fifo_empty && outstanding < 3));
        chk("m_valid", int'(m_valid), int'((outstanding - inflight_m) > 0));
        if (prev_valid && !prev_ready) chk("m_data_stable", int'(m_data), int'(prev_data));
        chk("word_cnt", int'(word_cnt), exp_cnt());
        pop_acc_s  = fifo_pop && !fifo_empty;
        xfer_s     = m_valid && m_ready;
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_data  = m_data;
        @(posedge rd_clk);
        #1;
        if (pop_acc_s && src_q.size() > 0) begin
            fifo_data = src_q.pop_front();
            exp_q.push_back(fifo_data);
        end
        outstanding = outstanding + int'(pop_acc_s) - int'(xfer_s);
        inflight_m  = int'(pop_acc_s);
        if (xfer_s) delivered++;
    endtask

    task automatic model_clear();
        src_q.delete();
        exp_q.delete();
        outstanding = 0;
        inflight_m  = 0;
        delivered   = 0;
        prev_valid  = 0;
        fifo_empty  = 1'b1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic reset_mid();
        #2 rd_rst = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_fifo_pop", int'(fifo_pop), 0);
        chk("rst_word_cnt", int'(word_cnt), 0);
        chk("rst_m_data", int'(m_data), 0);
        model_clear();
        @(negedge rd_clk);
        #1 rd_rst = 1'b1;
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        int guard;
        rd_rst     = 1'b0;
        en         = 1'b1;
        m_ready    = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = '0;
        repeat (2) @(negedge rd_clk);
        chk("reset_fifo_pop", int'(fifo_pop), 0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_data", int'(m_data), 0);
        chk("reset_word_cnt", int'(word_cnt), 0);
        fifo_empty = 1'b1;
        #1 rd_rst = 1'b1;
        @(posedge rd_clk);
        #1;

        // Three known words streamed with m_ready high.
        src_q.push_back(8'hA1);
        src_q.push_back(8'hA2);
        src_q.push_back(8'hA3);
        repeat (8) step(1'b1, 1'b1, 0);

        // Empty FIFO throughout.
        repeat (6) step(1'b1, 1'($urandom_range(0, 1)), 0);

        // Backpressure with five words, then release.
        step(1'b1, 1'b0, 5);
        repeat (7) step(1'b1, 1'b0, 0);
        repeat (8) step(1'b1, 1'b1, 0);

        // Enable dropped the cycle after a pop.
        step(1'b1, 1'b1, 4);
        repeat (6) step(1'b0, 1'b1, 0);
        repeat (6) step(1'b1, 1'b1, 0);

        // Mid-stream reset with two words buffered and a pop pending.
        step(1'b1, 1'b0, 2);
        guard = 0;
        while (!((outstanding - inflight_m) == 2 && inflight_m == 0) && guard < 10) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        chk("reach_occ2", int'((outstanding - inflight_m) == 2 && inflight_m == 0), 1);
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        fifo_empty = 1'b0;
        #1 chk("pop_before_reset", int'(fifo_pop), 1);
        reset_mid();

        // Seventeen transfers after reset with a 4-bit counter.
        repeat (25) step(1'b1, 1'b1, (delivered + outstanding + src_q.size() < 17) ? 1 : 0);
`ifdef FIFO_RD_STATS_EN
        chk("word_cnt_after_17", int'(word_cnt), 1);
`else
        chk("word_cnt_after_17", int'(word_cnt), 0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Drain everything that was popped.
        guard = 0;
        while ((outstanding > 0 || src_q.size() > 0) && guard < 200) begin
            step(1'b1, 1'b1, 0);
            guard++;
        end
        chk("drain_done", outstanding + src_q.size(), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
